// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory port between NUM_CORES cores.
// It uses the cores' grant_request/grant_given handshake. The grant is
// registered and one-hot, there is one dead turnaround cycle between owners,
// and a hold limit forces a release when another core is waiting.
//
// state   | meaning
// IDLE    | no grant, arbitrate every cycle
// OWNED   | grant_given[owner] high, owner's bus muxed onto memory
// RELEASE | one dead turnaround cycle, no grant, arbitrate
module mem_bus_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int MAX_HOLD  = 16,
    parameter int OWN_W     = $clog2(NUM_CORES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        grant_request,
    output logic [NUM_CORES-1:0]        grant_given,
    input  logic [NUM_CORES-1:0]        core_rw,
    input  logic [NUM_CORES*ADDR_W-1:0] core_address,
    input  logic [NUM_CORES*DATA_W-1:0] core_data_out,
    output logic [DATA_W-1:0]           core_data_in,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy,
    output logic [OWN_W-1:0]            owner
);

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OWNED   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [NUM_CORES-1:0] grant_q, grant_d;
    logic [OWN_W-1:0]     owner_q, owner_d;
    logic [OWN_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;

    logic                 arb_found;
    logic [OWN_W-1:0]     arb_winner;
    logic [NUM_CORES-1:0] own_mask;
    logic [NUM_CORES-1:0] win_mask;
    logic                 others_req;
    logic                 hold_at_limit;
    logic [OWN_W-1:0]     rr_next;
    int                   arb_idx;

    assign own_mask      = {{(NUM_CORES-1){1'b0}}, 1'b1} << owner_q;
    assign win_mask      = {{(NUM_CORES-1){1'b0}}, 1'b1} << arb_winner;
    assign others_req    = |(grant_request & ~own_mask);
    // Compare with >= so that a count already saturated at MAX_HOLD still
    // revokes the moment a competing request shows up.
    assign hold_at_limit = (MAX_HOLD != 0) && (int'(hold_cnt_q) >= MAX_HOLD - 1);
    assign rr_next       = (owner_q == OWN_W'(NUM_CORES - 1)) ? '0 : owner_q + 1'b1;

    // Round-robin search: first requester at or above rr_ptr, wrapping.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = '0;
        arb_idx    = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            arb_idx = int'(rr_ptr_q) + i;
            if (arb_idx >= NUM_CORES) begin
                arb_idx = arb_idx - NUM_CORES;
            end
            if (!arb_found && grant_request[arb_idx]) begin
                arb_found  = 1'b1;
                arb_winner = OWN_W'(arb_idx);
            end
        end
    end

    // Next-state logic for the ownership FSM, pointer and hold counter.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_OWNED: begin
                if (!grant_request[owner_q] || (hold_at_limit && others_req)) begin
                    state_d  = ST_RELEASE;
                    grant_d  = '0;
                    rr_ptr_d = rr_next;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                if (arb_found) begin
                    state_d    = ST_OWNED;
                    owner_d    = arb_winner;
                    grant_d    = win_mask;
                    hold_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any grant at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Memory-side mux, driven only from registered state so nothing leaks out
    // while idle or in the turnaround cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ST_OWNED) begin
            mem_we    = core_rw[owner_q];
            mem_addr  = core_address[owner_q*ADDR_W +: ADDR_W];
            mem_wdata = core_data_out[owner_q*DATA_W +: DATA_W];
        end
    end

    assign core_data_in = mem_rdata;
    assign grant_given  = grant_q;
    assign busy         = (state_q == ST_OWNED);
    assign owner        = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// random traffic, all compared each cycle against a behavioural model.
module tb_mem_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int MH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    grant_request;
    logic [N-1:0]    grant_given;
    logic [N-1:0]    core_rw;
    logic [N*AW-1:0] core_address;
    logic [N*DW-1:0] core_data_out;
    logic [DW-1:0]   core_data_in;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            busy;
    logic [1:0]      owner;

    mem_bus_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset), .grant_request(grant_request), .grant_given(grant_given),
        .core_rw(core_rw), .core_address(core_address), .core_data_out(core_data_out),
        .core_data_in(core_data_in), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Model: m_owned says a core holds the bus, m_turn marks the dead cycle,
    // m_held counts completed owned cycles (unbounded).
    bit   m_owned, m_turn;
    int   m_owner, m_rr, m_held;
    int   n_vec, n_err;
    bit   rec;
    logic [N-1:0] prev_gnt;
    int   order[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input int rr);
        for (int k = 0; k < N; k++) begin
            if (req[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_all();
        logic [N-1:0] eg;
        eg = m_owned ? N'(1 << m_owner) : '0;
        check("grant_given", 64'(grant_given), 64'(eg));
        check("busy", 64'(busy), 64'(m_owned));
        check("owner", 64'(owner), 64'(m_owner));
        check("mem_we", 64'(mem_we), m_owned ? 64'(core_rw[m_owner]) : 64'd0);
        check("mem_addr", 64'(mem_addr), m_owned ? 64'(core_address[m_owner*AW +: AW]) : 64'd0);
        check("mem_wdata", 64'(mem_wdata), m_owned ? 64'(core_data_out[m_owner*DW +: DW]) : 64'd0);
        check("core_data_in", 64'(core_data_in), 64'(mem_rdata));
        if (rec && grant_given != '0 && prev_gnt == '0) order.push_back(int'(owner));
        prev_gnt = grant_given;
    endtask

    task automatic model_edge();
        int w;
        bit others;
        if (reset) begin
            m_owned = 0; m_turn = 0; m_owner = 0; m_rr = 0; m_held = 0;
        end else if (m_owned) begin
            others = (grant_request & ~N'(1 << m_owner)) != '0;
            if (!grant_request[m_owner] || (MH != 0 && m_held + 1 >= MH && others)) begin
                m_owned = 0; m_turn = 1; m_rr = (m_owner + 1) % N;
            end else begin
                m_held++;
            end
        end else begin
            m_turn = 0;
            w = pick(grant_request, m_rr);
            if (w >= 0) begin
                m_owned = 1; m_owner = w; m_held = 0;
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] req, input logic rst, input logic [N-1:0] rw,
                         input logic [N*AW-1:0] addr, input logic [N*DW-1:0] dout,
                         input logic [DW-1:0] rdata);
        @(negedge clk);
        grant_request = req;
        reset         = rst;
        core_rw       = rw;
        core_address  = addr;
        core_data_out = dout;
        mem_rdata     = rdata;
        #1;
        check_all();
        @(posedge clk);
        model_edge();
    endtask

    task automatic rcycle(input logic [N-1:0] req, input logic rst);
        cycle(req, rst, N'($urandom), (N*AW)'({$urandom, $urandom}), (N*DW)'($urandom), DW'($urandom));
    endtask

    initial begin
        logic [N-1:0] req;
        n_vec = 0; n_err = 0; rec = 0; prev_gnt = '0;
        m_owned = 0; m_turn = 0; m_owner = 0; m_rr = 0; m_held = 0;
        grant_request = '0; reset = 1'b1; core_rw = '0; core_address = '0;
        core_data_out = '0; mem_rdata = '0;

        // Reset
        @(posedge clk);
        rcycle('0, 1'b1);
        rcycle('0, 1'b1);
        rcycle('0, 1'b0);

        // Single requester core 2, then release
        for (int i = 0; i < 8; i++) rcycle(4'b0100, 1'b0);
        check("single_grant", 64'(grant_given), 64'h4);
        for (int i = 0; i < 4; i++) rcycle(4'b0000, 1'b0);

        // Simultaneous requests 1011; each owner drops after 3 owned cycles
        rcycle('0, 1'b1);
        rec = 1;
        for (int i = 0; i < 24; i++) begin
            req = 4'b1011;
            if (m_owned && m_held >= 3) req[m_owner] = 1'b0;
            rcycle(req, 1'b0);
        end
        rec = 0;
        check("order_len", 64'(order.size() >= 4), 64'd1);
        if (order.size() >= 4) begin
            check("order0", 64'(order[0]), 64'd0);
            check("order1", 64'(order[1]), 64'd1);
            check("order2", 64'(order[2]), 64'd3);
            check("order3", 64'(order[3]), 64'd0);
        end

        // Hold limit: core 1 holds, core 2 joins and leaves after 2 owned cycles
        rcycle('0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            req = 4'b0010;
            if (i >= 3 && i < 12) req[2] = 1'b1;
            if (m_owned && m_owner == 2 && m_held >= 2) req[2] = 1'b0;
            rcycle(req, 1'b0);
        end

        // Write passthrough from core 3
        rcycle('0, 1'b1);
        for (int i = 0; i < 5; i++)
            cycle(4'b1000, 1'b0, 4'b1000, {9'h1A5, 27'h0}, {8'h55, 24'h0}, 8'hC3);
        check("wr_addr", 64'(mem_addr), 64'h1A5);
        check("wr_data", 64'(mem_wdata), 64'h55);
        for (int i = 0; i < 3; i++)
            cycle(4'b0000, 1'b0, 4'b1000, {9'h1A5, 27'h0}, {8'h55, 24'h0}, 8'hC3);

        // Reset mid-ownership of core 0
        for (int i = 0; i < 4; i++) rcycle(4'b0001, 1'b0);
        rcycle(4'b0001, 1'b1);
        for (int i = 0; i < 4; i++) rcycle(4'b0001, 1'b0);

        // Random traffic with sticky requests and rare resets
        req = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 4) == 0) req[b] = ~req[b];
            end
            rcycle(req, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
